// File: rtl/lvdc_io_port_if.sv
// CPU-side bus of the LVDC I/O port: port select, active-low strobes and data.
interface lvdc_io_port_if #(
  parameter int DATA_W = 26,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] I;
  logic              nIOR;
  logic              nIOW;
  logic [DATA_W-1:0] db_in;
  logic [DATA_W-1:0] db_out;
  logic              db_oe;

  modport master (output I, nIOR, nIOW, db_in, input db_out, db_oe);
  modport slave  (input I, nIOR, nIOW, db_in, output db_out, db_oe);
endinterface

// File: rtl/lvdc_io_port.sv
// LVDC I/O port controller: GPO latches, GPI port, mode-0 SPI master and
// a maskable edge-latched interrupt controller behind a strobed CPU bus.
module lvdc_io_port #(
  parameter int DATA_W  = 26,
  parameter int ADDR_W  = 4,
  parameter int N_GPO   = 2,
  parameter int GPO_W   = 8,
  parameter int SPI_W   = 8,
  parameter int SPI_DIV = 2,
  parameter int N_INT   = 4
) (
  input  logic                   clk,
  input  logic                   rstb,
  lvdc_io_port_if.slave          bus,
  output logic [N_GPO*GPO_W-1:0] gpo,
  input  logic [GPO_W-1:0]       gpi,
  input  logic [N_INT-1:0]       int_src,
  input  logic                   int_inhibit,
  output logic                   interrupt,
  output logic                   spi_cs_n,
  output logic                   sck,
  output logic                   sdo,
  input  logic                   sdi
);
  localparam logic [ADDR_W-1:0] P_SPI  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] P_STAT = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] P_CTRL = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] P_ICLR = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] P_GPI  = ADDR_W'(12);
  localparam int DIV_CW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int BIT_CW = $clog2(SPI_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} spi_state_t;

  logic [1:0]             nior_sy, niow_sy;
  logic                   nior_d, niow_d;
  logic [GPO_W-1:0]       gpi_sy0, gpi_sy1;
  logic [N_INT-1:0]       int_sy0, int_sy1, int_prev;
  logic                   rd_pulse, wr_pulse, rd_take;
  logic                   wr_spi;
  logic [N_INT-1:0]       int_rise, iclr;

  logic [N_GPO-1:0][GPO_W-1:0] gpo_r;
  logic [N_INT-1:0]       mask, pending;
  logic                   cs_force, overrun;
  logic [DATA_W-1:0]      rdata;

  spi_state_t             spi_state, spi_next;
  logic [DIV_CW-1:0]      div_cnt;
  logic [BIT_CW-1:0]      bit_cnt;
  logic [SPI_W-1:0]       sh, spi_rx;
  logic                   sdi_q;
  logic                   tick, busy;
  logic                   unused_db;

  assign unused_db = ^bus.db_in;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      nior_sy  <= '1;
      niow_sy  <= '1;
      nior_d   <= 1'b1;
      niow_d   <= 1'b1;
      gpi_sy0  <= '0;
      gpi_sy1  <= '0;
      int_sy0  <= '0;
      int_sy1  <= '0;
      int_prev <= '0;
    end else begin
      nior_sy  <= {nior_sy[0], bus.nIOR};
      niow_sy  <= {niow_sy[0], bus.nIOW};
      nior_d   <= nior_sy[1];
      niow_d   <= niow_sy[1];
      gpi_sy0  <= gpi;
      gpi_sy1  <= gpi_sy0;
      int_sy0  <= int_src;
      int_sy1  <= int_sy0;
      int_prev <= int_sy1;
    end
  end

  assign rd_pulse = nior_d & ~nior_sy[1];
  assign wr_pulse = niow_d & ~niow_sy[1];
  // A simultaneous write wins; the read pulse is simply dropped.
  assign rd_take  = rd_pulse & ~wr_pulse;
  assign wr_spi   = wr_pulse && (bus.I == P_SPI);
  assign int_rise = int_sy1 & ~int_prev;
  assign iclr     = (wr_pulse && (bus.I == P_ICLR)) ? bus.db_in[N_INT-1:0] : '0;

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < N_GPO; k++)
      if (bus.I == ADDR_W'(k)) rdata = DATA_W'(gpo_r[k]);
    case (bus.I)
      P_SPI:  rdata = DATA_W'(spi_rx);
      P_STAT: begin
        rdata[0]           = busy;
        rdata[1]           = overrun;
        rdata[2]           = interrupt;
        rdata[N_INT+7:8]   = pending;
      end
      P_CTRL: begin
        rdata[N_INT-1:0] = mask;
        rdata[8]         = cs_force;
      end
      P_GPI:  rdata = DATA_W'(gpi_sy1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gpo_r      <= '0;
      mask       <= '0;
      cs_force   <= 1'b0;
      pending    <= '0;
      overrun    <= 1'b0;
      interrupt  <= 1'b0;
      bus.db_out <= '0;
      bus.db_oe  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_GPO; k++)
        if (wr_pulse && (bus.I == ADDR_W'(k))) gpo_r[k] <= bus.db_in[GPO_W-1:0];
      if (wr_pulse && (bus.I == P_CTRL)) begin
        mask     <= bus.db_in[N_INT-1:0];
        cs_force <= bus.db_in[8];
      end
      // New edges take priority over a same-cycle clear.
      pending   <= (pending & ~iclr) | int_rise;
      interrupt <= |(pending & mask) & ~int_inhibit;
      if (wr_spi && (spi_state != S_IDLE)) overrun <= 1'b1;
      else if (rd_take && (bus.I == P_STAT)) overrun <= 1'b0;
      if (rd_take) begin
        bus.db_out <= rdata;
        bus.db_oe  <= 1'b1;
      end else if (nior_sy[1]) begin
        bus.db_out <= '0;
        bus.db_oe  <= 1'b0;
      end
    end
  end

  assign gpo  = gpo_r;
  assign tick = (div_cnt == DIV_CW'(SPI_DIV - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) spi_state <= S_IDLE;
    else       spi_state <= spi_next;
  end

  // DONE is entered on the last falling sck, so the shift register is complete.
  always_comb begin
    spi_next = spi_state;
    case (spi_state)
      S_IDLE:  if (wr_spi) spi_next = S_SHIFT;
      S_SHIFT: if (tick && sck && (bit_cnt == BIT_CW'(SPI_W - 1))) spi_next = S_DONE;
      S_DONE:  spi_next = S_IDLE;
      default: spi_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (spi_state != S_IDLE);
    spi_cs_n = (spi_state == S_IDLE) ? ~cs_force : 1'b0;
    sdo      = (spi_state == S_SHIFT) ? sh[SPI_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      sh      <= '0;
      spi_rx  <= '0;
      sdi_q   <= 1'b0;
    end else begin
      case (spi_state)
        S_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          sck     <= 1'b0;
          if (wr_spi) sh <= bus.db_in[SPI_W-1:0];
        end
        S_SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
            if (sck) begin
              sh      <= (sh << 1) | SPI_W'(sdi_q);
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sdi_q <= sdi;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE:  spi_rx <= sh;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/lvdc_io_port.md
# lvdc_io_port

Parametrised, synthesizable I/O port controller for the LVDC core. It replaces the bench-only glue between the processor's data bus, the port-select lines and the `nIOR`/`nIOW` strobes with a clocked block. The block provides configurable GPIO output latches, a GPIO input port, an SPI master for the boot flash, and a maskable, edge-latched interrupt controller. It sits between the CPU bus pins and the board peripherals (lamps, flash, interrupt sources).

## Interface
- `DATA_W`, 26: CPU data-bus width.
- `ADDR_W`, 4: port-select width (CPU `I[8:5]`).
- `N_GPO`, 2: number of GPIO output latches. Range 1..8.
- `GPO_W`, 8: width of each output latch and of the input port. Must be ≤ `DATA_W`.
- `SPI_W`, 8: SPI transfer length in bits. Range 1..`DATA_W`.
- `SPI_DIV`, 2: half-period of `sck` in `clk` cycles. Must be ≥ 1.
- `N_INT`, 4: interrupt source count. Must be ≤ `DATA_W`/2.

Ports:
- `clk` in 1: sole clock.
- `rstb` in 1: asynchronous, active-low reset.
- `I` in `ADDR_W`: port select. Asynchronous; captured on the strobe edge.
- `nIOR`, `nIOW` in 1 each: active-low strobes. Asynchronous.
- `db_in` in `DATA_W`: bus write data.
- `db_out` out `DATA_W`: bus read data.
- `db_oe` out 1: bus drive enable. Also serves as `BDIR`.
- `gpo` out `N_GPO*GPO_W`: output latches. Latch k occupies bits [k*GPO_W +: GPO_W].
- `gpi` in `GPO_W`: input port. Asynchronous.
- `int_src` in `N_INT`: interrupt request lines. Asynchronous, rising-edge sensitive.
- `int_inhibit` in 1: global interrupt inhibit.
- `interrupt` out 1: interrupt request to CPU.
- `spi_cs_n`, `sck`, `sdo` out 1 each; `sdi` in 1: SPI master pins.

## Operation
- Synchronisation:
  - `nIOR`, `nIOW`, `gpi` and `int_src` each pass through a 2-flop synchroniser.
  - A falling edge on synchronised `nIOW` produces a one-cycle write pulse.
  - A falling edge on synchronised `nIOR` produces a one-cycle read pulse.
  - `I` and `db_in` are sampled on the same cycle as the pulse.
- Register map (port = `I`):
  - 0..`N_GPO`-1: GPO latch, read/write. Only `db_in[GPO_W-1:0]` is stored.
  - 8: SPI data. A write starts a transfer. A read returns the last received word, zero-extended.
  - 9: status, read-only.
    - [0] `busy`.
    - [1] `overrun`. Sticky; cleared by reading port 9.
    - [2] `interrupt`.
    - [N_INT+7:8] pending.
  - 10: control, read/write.
    - [N_INT-1:0] mask; 1 = enabled.
    - [8] `cs_force`: manual chip-select. When set, `spi_cs_n`=0.
  - 11: interrupt clear, write-one-to-clear on pending. Reads return 0.
  - 12: GPI, read-only, synchronised value.
  - All other ports: writes are ignored; reads return 0.
- Read path:
  - On the read pulse, `db_out` registers the addressed value and `db_oe` goes to 1.
  - Both hold until synchronised `nIOR` returns high, then `db_oe` goes to 0.
  - `db_out` is 0 whenever `db_oe`=0.
  - If both strobes are low at once, the write is taken and the read is ignored.
- SPI master, mode 0, MSB first. States IDLE → SHIFT → DONE → IDLE.
  - IDLE: `busy`=0, `sck`=0, `spi_cs_n`=~`cs_force`.
  - A port-8 write in IDLE loads the shift register and enters SHIFT.
  - A port-8 write while not IDLE is dropped and sets `overrun`.
  - SHIFT: `spi_cs_n`=0. `sdo` presents the MSB. `sck` toggles every `SPI_DIV` cycles. `sdi` is sampled on rising `sck` and the register shifts on falling `sck`.
  - After `SPI_W` rising edges, the block goes to DONE.
  - DONE (1 cycle): copy received word to the read register, then return to IDLE.
- Interrupts:
  - A rising edge of a synchronised `int_src[i]` sets `pending[i]`.
  - A clear (port-11 write) and a new edge on the same cycle leave the bit set.
  - `interrupt` is registered: `|(pending & mask) & ~int_inhibit`.

## Timing
- Reset values:
  - `gpo`=0, `db_out`=0, `db_oe`=0.
  - `interrupt`=0, pending=0, mask=0, `overrun`=0, `cs_force`=0.
  - `spi_cs_n`=1, `sck`=0, `sdo`=0, SPI state IDLE.
- Reset mid-transfer aborts immediately to these values.
- Write latency: a register updates on the 3rd `clk` rising edge after `nIOW` is low at a sampling edge (2 synchroniser stages + pulse).
- Read latency: `db_oe`=1 and data are valid on the 3rd edge after `nIOR` is low. `db_oe` drops on the 3rd edge after `nIOR` rises.
- CPU strobes must be held low for at least 4 `clk` cycles and high for at least 4.
- SPI transfer: `busy` rises 1 cycle after the write pulse. The transfer lasts `2*SPI_DIV*SPI_W` cycles plus 1 DONE cycle.
- `interrupt` rises 4 cycles after the `int_src` edge: 2 sync, 1 edge detect/pending, 1 output register.

## Test plan
- Reset: hold `rstb`=0 with strobes toggling → all outputs at their reset values and `db_oe` never asserts.
- GPO: write 0x3A5 to port 1 (`GPO_W`=8) → `gpo[15:8]`=0xA5 three edges after `nIOW` low. Read port 1 → `db_out`=0x0A5 with `db_oe`=1, then `db_oe`=0 after release.
- SPI (`SPI_W`=8, `SPI_DIV`=2), `sdi` driven as loopback of `sdo`:
  - Write 0xC3 to port 8 → 8 `sck` pulses, each of period 4 cycles, with `spi_cs_n`=0 throughout.
  - Afterwards, reading port 8 returns 0xC3.
  - A second write issued mid-transfer → status reads `overrun`=1, and the next status read returns 0.
- Interrupt, with mask=0b0101:
  - Pulse `int_src[2]` → `interrupt` rises 4 cycles later.
  - Pulse `int_src[1]` → pending[1]=1 but no change to `interrupt`.
  - Assert `int_inhibit` → `interrupt` falls next cycle.
  - Write 0b0100 to port 11 → pending=0b0010 and `interrupt` stays 0 after the inhibit is released.
- Simultaneous strobes: both `nIOR` and `nIOW` low at port 0 → the latch is written and `db_oe` stays 0.
- Unmapped port 15: a write has no effect; a read returns 0 with `db_oe`=1.
